sevseg_scan_driver: RTL and testbench

Time-multiplexed driver for a common-anode seven-segment bank of `NUM_DIGITS` digits. Each digit is lit in turn for a programmable dwell time. It supersedes the static per-digit decode path by adding several features:
- shadow-buffered, frame-atomic value updates;
- per-digit enable and blink;
- optional leading-zero suppression.

It sits between the UART/debug datapath, which produces nibble values, and the board's shared segment and anode pins.

---
 rtl/sevseg_pkg.sv | 15 +
 rtl/sevseg_font_decode.sv | 11 +
 rtl/sevseg_scan_driver.sv | 174 +++++++++++++++++
 tb/tb_sevseg_scan_driver.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// Shared definitions for the seven-segment scan driver: nibble type,
// blank pattern and the active-low {g,f,e,d,c,b,a} hex font.
package sevseg_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n is the glyph for hex digit n (0 = segment lit).
  localparam logic [15:0][6:0] FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/sevseg_font_decode.sv
// Combinational hex-nibble to active-low seven-segment glyph lookup.
module sevseg_font_decode
  import sevseg_pkg::*;
(
  input  nibble_t    nibble,
  output logic [6:0] seg
);

  assign seg = FONT[nibble];

endmodule

// File: rtl/sevseg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with frame-atomic shadow
// updates, per-digit enable and blink. Define SEVSEG_LZ_SUPPRESS_EN for leading-zero blanking.
module sevseg_scan_driver
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   turn_on,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic                    load,
  output logic [6:0]              segment,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PCNT_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FCNT_MAX = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]           pcnt_q, pcnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [FW-1:0]           fcnt_q, fcnt_d;
  logic                    phase_q, phase_d;
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] stg_value_q, stg_value_d;
  logic [NUM_DIGITS-1:0]   stg_on_q, stg_on_d;
  logic [NUM_DIGITS-1:0]   stg_blink_q, stg_blink_d;
  logic [4*NUM_DIGITS-1:0] sh_value_q, sh_value_d;
  logic [NUM_DIGITS-1:0]   sh_on_q, sh_on_d;
  logic [NUM_DIGITS-1:0]   sh_blink_q, sh_blink_d;
  logic [6:0]              segment_q, segment_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;

  logic       tick;
  logic       boundary;
  nibble_t    sel_nib;
  logic       sel_on;
  logic       sel_blink;
  logic [6:0] font_seg;
`ifdef SEVSEG_LZ_SUPPRESS_EN
  logic       lz_blank;
`endif

  // Scan timing, staging/shadow handshake and blink phase.
  always_comb begin
    tick     = (pcnt_q == PCNT_MAX);
    boundary = tick && (idx_q == IDX_MAX);

    pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    idx_d  = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end

    stg_value_d = stg_value_q;
    stg_on_d    = stg_on_q;
    stg_blink_d = stg_blink_q;
    if (load) begin
      stg_value_d = value;
      stg_on_d    = turn_on;
      stg_blink_d = blink;
    end

    pending_d = boundary ? 1'b0 : (load ? 1'b1 : pending_q);

    // A load landing on the boundary cycle bypasses staging.
    sh_value_d = sh_value_q;
    sh_on_d    = sh_on_q;
    sh_blink_d = sh_blink_q;
    if (boundary && (pending_q || load)) begin
      sh_value_d = load ? value   : stg_value_q;
      sh_on_d    = load ? turn_on : stg_on_q;
      sh_blink_d = load ? blink   : stg_blink_q;
    end

    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (boundary) begin
      if (fcnt_q == FCNT_MAX) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  // Outputs are registered from next-state values so the new shadow shows on digit 0 at once.
  always_comb begin
    sel_nib   = '0;
    sel_on    = 1'b0;
    sel_blink = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        sel_nib   = sh_value_d[4*k +: 4];
        sel_on    = sh_on_d[k];
        sel_blink = sh_blink_d[k];
      end
    end
`ifdef SEVSEG_LZ_SUPPRESS_EN
    lz_blank = (idx_d != '0) && (sel_nib == '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((IW'(k) > idx_d) && sh_on_d[k] && (sh_value_d[4*k +: 4] != '0)) begin
        lz_blank = 1'b0;
      end
    end
`endif
  end

  sevseg_font_decode u_font (
    .nibble (sel_nib),
    .seg    (font_seg)
  );

  always_comb begin
    segment_d = font_seg;
    if (!sel_on || (phase_d && sel_blink)
`ifdef SEVSEG_LZ_SUPPRESS_EN
        || lz_blank
`endif
       ) begin
      segment_d = SEG_BLANK;
    end
    anode_d = ~(NUM_DIGITS'(1) << idx_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pcnt_q      <= '0;
      idx_q       <= '0;
      fcnt_q      <= '0;
      phase_q     <= 1'b0;
      pending_q   <= 1'b0;
      stg_value_q <= '0;
      stg_on_q    <= '0;
      stg_blink_q <= '0;
      sh_value_q  <= '0;
      sh_on_q     <= '0;
      sh_blink_q  <= '0;
      segment_q   <= SEG_BLANK;
      anode_q     <= '1;
    end else begin
      pcnt_q      <= pcnt_d;
      idx_q       <= idx_d;
      fcnt_q      <= fcnt_d;
      phase_q     <= phase_d;
      pending_q   <= pending_d;
      stg_value_q <= stg_value_d;
      stg_on_q    <= stg_on_d;
      stg_blink_q <= stg_blink_d;
      sh_value_q  <= sh_value_d;
      sh_on_q     <= sh_on_d;
      sh_blink_q  <= sh_blink_d;
      segment_q   <= segment_d;
      anode_q     <= anode_d;
    end
  end

  assign segment    = segment_q;
  assign anode      = anode_q;
  assign frame_done = boundary;
  assign pending    = pending_q;

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Directed bench for sevseg_scan_driver with 4 digits, 4-cycle dwell, 2-frame blink.
module tb_sevseg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BF = 2;
  localparam logic [27:0] BLANK4 = {4{7'h7F}};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load  = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  turn_on = '0;
  logic [3:0]  blink = '0;
  logic [6:0]  segment;
  logic [3:0]  anode;
  logic        frame_done;
  logic        pending;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clock = ~clock;

  sevseg_scan_driver #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .value      (value),
    .turn_on    (turn_on),
    .blink      (blink),
    .load       (load),
    .segment    (segment),
    .anode      (anode),
    .frame_done (frame_done),
    .pending    (pending)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; a load strobe set before the call lasts exactly one edge.
  task automatic step();
    @(posedge clock);
    #1 load = 1'b0;
    @(negedge clock);
    cyc++;
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (frame_done !== 1'b1 && n < 40);
    check_eq("frame_done seen", 32'(frame_done), 32'd1);
  endtask

  // Called from a boundary cycle; walks one full frame and ends on the next boundary.
  task automatic check_frame(input string tag, input logic [27:0] segs);
    logic [3:0] an_exp;
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < RD; c++) begin
        step();
        if (c == 0 || c == RD - 1) begin
          an_exp = ~(4'b0001 << d);
          check_eq($sformatf("%s anode d%0d c%0d", tag, d, c), 32'(anode), 32'(an_exp));
          check_eq($sformatf("%s seg d%0d c%0d", tag, d, c), 32'(segment), 32'(segs[7*d +: 7]));
        end
      end
    end
    check_eq({tag, " boundary"}, 32'(frame_done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    logic [6:0]  d0;
    logic [27:0] exp;

    // Reset and idle scan
    step();
    step();
    check_eq("rst anode", 32'(anode), 32'hF);
    check_eq("rst segment", 32'(segment), 32'h7F);
    check_eq("rst pending", 32'(pending), 32'd0);
    check_eq("rst frame_done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    cyc = 0;
    step();
    check_eq("first anode", 32'(anode), 32'hE);
    check_eq("first segment", 32'(segment), 32'h7F);
    wait_frame(n);
    check_eq("first frame latency", 32'(n), 32'd14);
    check_frame("idle", BLANK4);

    // Mid-frame load commits at the boundary
    repeat (6) step();
    value = 16'h12AF; turn_on = 4'hF; blink = 4'h0; load = 1'b1;
    step();
    check_eq("pending after load", 32'(pending), 32'd1);
    wait_frame(n);
    check_eq("pending at boundary", 32'(pending), 32'd1);
    check_frame("commit", {7'h79, 7'h24, 7'h08, 7'h0E});
    check_eq("pending cleared", 32'(pending), 32'd0);

    // Last load wins; live value changes without load are ignored
    repeat (3) step();
    value = 16'h1111; load = 1'b1;
    step();
    repeat (2) step();
    value = 16'h2222; load = 1'b1;
    step();
    value = 16'h9999;
    wait_frame(n);
    check_frame("lastwins", {4{7'h24}});

    // Load on the boundary cycle is bypassed into the next frame
    value = 16'h3456; load = 1'b1;
    check_frame("bypass", {7'h30, 7'h19, 7'h12, 7'h02});
    check_eq("bypass pending", 32'(pending), 32'd0);

    // Blink on digit 0: phase flips every BF frames counted from reset
    blink = 4'b0001; load = 1'b1;
    for (int f = 0; f < 4; f++) begin
      k  = (cyc + 1) / (ND * RD);
      d0 = (((k / BF) % 2) == 1) ? 7'h7F : 7'h02;
      check_frame($sformatf("blink f%0d", f), {7'h30, 7'h19, 7'h12, d0});
    end

    // Leading-zero handling
    value = 16'h0070; turn_on = 4'hF; blink = 4'h0; load = 1'b1;
`ifdef SEVSEG_LZ_SUPPRESS_EN
    exp = {7'h7F, 7'h7F, 7'h78, 7'h40};
`else
    exp = {7'h40, 7'h40, 7'h78, 7'h40};
`endif
    check_frame("lz 0070", exp);
    value = 16'h0000; load = 1'b1;
`ifdef SEVSEG_LZ_SUPPRESS_EN
    exp = {7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
    exp = {4{7'h40}};
`endif
    check_frame("lz 0000", exp);
    value = 16'h5070; turn_on = 4'b0111; load = 1'b1;
`ifdef SEVSEG_LZ_SUPPRESS_EN
    exp = {7'h7F, 7'h7F, 7'h78, 7'h40};
`else
    exp = {7'h7F, 7'h40, 7'h78, 7'h40};
`endif
    check_frame("lz disabled top", exp);

    // Reset in the middle of digit 2 with data pending
    step();
    value = 16'hBEEF; turn_on = 4'hF; load = 1'b1;
    step();
    check_eq("pending before reset", 32'(pending), 32'd1);
    for (int i = 0; i < 16 && (cyc % 16) != 9; i++) step();
    check_eq("mid digit2 anode", 32'(anode), 32'hB);
    reset = 1'b1;
    step();
    check_eq("midrst anode", 32'(anode), 32'hF);
    check_eq("midrst pending", 32'(pending), 32'd0);
    check_eq("midrst segment", 32'(segment), 32'h7F);
    check_eq("midrst frame_done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    cyc = 0;
    step();
    check_eq("restart anode", 32'(anode), 32'hE);
    check_eq("restart segment", 32'(segment), 32'h7F);
    wait_frame(n);
    check_eq("restart latency", 32'(n), 32'd14);
    check_frame("post reset", BLANK4);
    check_eq("post reset pending", 32'(pending), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
